// File: rtl/t03_timer_alarm.sv
// Memory-mapped view of the hardware clock count with an alarm compare, optional
// periodic reload and a level interrupt, behind a req/ack word bus.
module t03_timer_alarm #(
  parameter logic [31:0] ALARM_RST  = 32'hFFFF_FFFF,
  parameter logic [31:0] PERIOD_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_counter_in,
  input  logic        i_bus_req,
  input  logic        i_bus_we,
  input  logic [1:0]  i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_ack,
  output logic        o_irq
);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_alarm, r_period, r_prev;
  logic        r_en, r_periodic, r_ie, r_pending, r_missed;

  logic [31:0] w_alarm_nxt, w_period_nxt, w_ctrl_nxt, w_rd_mux, w_rdata_nxt;
  logic        w_en_nxt, w_periodic_nxt, w_ie_nxt, w_pending_nxt, w_missed_nxt;
  logic        w_acc, w_wr, w_tick, w_hit, w_ack_nxt;
  logic        w_wr_alarm, w_wr_period, w_wr_ctrl;

  assign w_acc       = (r_state == S_IDLE) && i_bus_req;
  assign w_wr        = w_acc && i_bus_we;
  assign w_wr_alarm  = w_wr && (i_bus_addr == 2'd1);
  assign w_wr_period = w_wr && (i_bus_addr == 2'd2);
  assign w_wr_ctrl   = w_wr && (i_bus_addr == 2'd3);

  // Hit uses pre-write ALARM and en, so a same-cycle CPU write never masks it
  assign w_tick = (i_counter_in != r_prev);
  assign w_hit  = r_en && w_tick && (i_counter_in == r_alarm);

  always_comb begin
    w_alarm_nxt = r_alarm;
    if (w_wr_alarm)              w_alarm_nxt = i_bus_wdata;
    else if (w_hit && r_periodic) w_alarm_nxt = r_alarm + r_period;
  end

  assign w_period_nxt   = w_wr_period ? i_bus_wdata : r_period;
  assign w_en_nxt       = w_wr_ctrl ? i_bus_wdata[0] : r_en;
  assign w_periodic_nxt = w_wr_ctrl ? i_bus_wdata[1] : r_periodic;
  assign w_ie_nxt       = w_wr_ctrl ? i_bus_wdata[2] : r_ie;
  // W1C loses to a same-cycle hit; missed looks at pending before the clear
  assign w_pending_nxt  = w_hit || (r_pending && !(w_wr_ctrl && i_bus_wdata[8]));
  assign w_missed_nxt   = (w_hit && r_pending) || (r_missed && !(w_wr_ctrl && i_bus_wdata[9]));
  assign w_ctrl_nxt     = {22'd0, w_missed_nxt, w_pending_nxt, 5'd0,
                           w_ie_nxt, w_periodic_nxt, w_en_nxt};

  always_comb begin
    case (i_bus_addr)
      2'd0:    w_rd_mux = i_counter_in;
      2'd1:    w_rd_mux = w_alarm_nxt;
      2'd2:    w_rd_mux = w_period_nxt;
      default: w_rd_mux = w_ctrl_nxt;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_rdata_nxt = 32'd0;
    case (r_state)
      S_IDLE: if (i_bus_req) begin
        w_state_nxt = S_RESP;
        w_ack_nxt   = 1'b1;
        if (!i_bus_we) w_rdata_nxt = w_rd_mux;
      end
      S_RESP: w_state_nxt = S_DROP;
      S_DROP: if (!i_bus_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      o_bus_ack   <= 1'b0;
      o_bus_rdata <= 32'd0;
      r_alarm     <= ALARM_RST;
      r_period    <= PERIOD_RST;
      r_prev      <= 32'd0;
      r_en        <= 1'b0;
      r_periodic  <= 1'b0;
      r_ie        <= 1'b0;
      r_pending   <= 1'b0;
      r_missed    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      o_bus_ack   <= w_ack_nxt;
      o_bus_rdata <= w_rdata_nxt;
      r_alarm     <= w_alarm_nxt;
      r_period    <= w_period_nxt;
      r_prev      <= i_counter_in;
      r_en        <= w_en_nxt;
      r_periodic  <= w_periodic_nxt;
      r_ie        <= w_ie_nxt;
      r_pending   <= w_pending_nxt;
      r_missed    <= w_missed_nxt;
    end
  end

  assign o_irq = r_pending && r_ie;

endmodule

// File: tb/tb_t03_timer_alarm.sv
// Directed bench for t03_timer_alarm: table-driven bus ops plus hand sequences.
module tb_t03_timer_alarm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt;
  logic        req, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack, irq;

  int n_tests = 0;
  int n_fail  = 0;

  t03_timer_alarm dut (
    .clk(clk), .rst(rst), .i_counter_in(cnt), .i_bus_req(req), .i_bus_we(we),
    .i_bus_addr(addr), .i_bus_wdata(wdata), .o_bus_rdata(rdata), .o_bus_ack(ack),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic w, logic [1:0] a, logic [31:0] d,
                              logic c, logic [31:0] e, logic ei);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.wdata = d;
    v.chk_rd = c; v.exp_rd = e; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One full transaction; optionally changes the count in the request cycle
  task automatic bus_op(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic set_cnt, input logic [31:0] cval,
                        output logic [31:0] rd);
    logic got;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    if (set_cnt) cnt = cval;
    got = 1'b0;
    rd  = 32'hDEAD_BEEF;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; rd = rdata; end
    end
    if (!got) chk("ack_timeout", {31'd0, got}, 32'd1);
    req = 1'b0; we = 1'b0; wdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_tbl();
    logic [31:0] rd;
    foreach (tbl[i]) begin
      bus_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, 32'd0, rd);
      if (tbl[i].chk_rd) chk({tbl[i].name, " rdata"}, rd, tbl[i].exp_rd);
      chk({tbl[i].name, " irq"}, {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end
    tbl.delete();
  endtask

  task automatic step_cnt(input logic [31:0] v);
    @(negedge clk);
    cnt = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int acks;
    rst = 1'b1; cnt = 32'd0; req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst ack",   {31'd0, ack}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst irq",   {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Reset values and basic one-shot alarm setup
    tbl.push_back(mk("rd alarm rst",  0, 1, 0,            1, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk("rd ctrl rst",   0, 3, 0,            1, 32'h0,         0));
    tbl.push_back(mk("rd period rst", 0, 2, 0,            1, 32'h0,         0));
    tbl.push_back(mk("wr count",      1, 0, 32'h1234,     0, 0,             0));
    tbl.push_back(mk("rd count ro",   0, 0, 0,            1, 32'h0,         0));
    tbl.push_back(mk("wr alarm5",     1, 1, 32'd5,        0, 0,             0));
    tbl.push_back(mk("wr ctrl5",      1, 3, 32'hFFFF_FCF5, 0, 0,            0));
    tbl.push_back(mk("rd ctrl5",      0, 3, 0,            1, 32'h5,         0));
    tbl.push_back(mk("rd alarm5",     0, 1, 0,            1, 32'd5,         0));
    run_tbl();

    for (int v = 1; v <= 6; v++) begin
      step_cnt(v);
      @(negedge clk);
      chk($sformatf("ramp irq c=%0d", v), {31'd0, irq}, {31'd0, (v >= 5)});
    end
    tbl.push_back(mk("rd ctrl hit",   0, 3, 0,        1, 32'h105, 1));
    tbl.push_back(mk("w1c pending",   1, 3, 32'h100,  0, 0,       0));
    tbl.push_back(mk("rd ctrl clr",   0, 3, 0,        1, 32'h0,   0));
    tbl.push_back(mk("rd count 6",    0, 0, 0,        1, 32'd6,   0));
    tbl.push_back(mk("wr alarm10",    1, 1, 32'd10,   0, 0,       0));
    tbl.push_back(mk("wr period3",    1, 2, 32'd3,    0, 0,       0));
    tbl.push_back(mk("wr ctrl7",      1, 3, 32'h7,    0, 0,       0));
    run_tbl();

    // Periodic: hits at 10, 13, 16 without clearing
    for (int v = 7; v <= 13; v++) step_cnt(v);
    @(negedge clk);
    tbl.push_back(mk("rd ctrl missed", 0, 3, 0, 1, 32'h307, 1));
    tbl.push_back(mk("rd alarm16",     0, 1, 0, 1, 32'd16,  1));
    run_tbl();
    for (int v = 14; v <= 16; v++) step_cnt(v);
    @(negedge clk);
    tbl.push_back(mk("rd alarm19",    0, 1, 0,             1, 32'd19, 1));
    tbl.push_back(mk("clr all",       1, 3, 32'h300,       0, 0,      0));
    tbl.push_back(mk("rd ctrl 0",     0, 3, 0,             1, 32'h0,  0));
    tbl.push_back(mk("wr alarm wrap", 1, 1, 32'hFFFF_FFFE, 0, 0,      0));
    tbl.push_back(mk("wr period4",    1, 2, 32'd4,         0, 0,      0));
    tbl.push_back(mk("wr ctrl3",      1, 3, 32'h3,         0, 0,      0));
    run_tbl();

    // Wrap of the periodic reload; ie=0 keeps irq low despite pending
    step_cnt(32'hFFFF_FFFE);
    @(negedge clk);
    tbl.push_back(mk("rd alarm wrap", 0, 1, 0,        1, 32'h2,   0));
    tbl.push_back(mk("rd ctrl noie",  0, 3, 0,        1, 32'h103, 0));
    tbl.push_back(mk("clr wrap",      1, 3, 32'h300,  0, 0,       0));
    tbl.push_back(mk("wr period0",    1, 2, 32'd0,    0, 0,       0));
    tbl.push_back(mk("wr alarm50",    1, 1, 32'h50,   0, 0,       0));
    tbl.push_back(mk("wr ctrl oneshot", 1, 3, 32'h5,  0, 0,       0));
    run_tbl();

    // Held request: one ack, count parked on the alarm value hits once
    step_cnt(32'h50);
    @(negedge clk);
    chk("held pre irq", {31'd0, irq}, 32'd1);
    req = 1'b1; we = 1'b1; addr = 2'd3; wdata = 32'h105;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) acks++;
    end
    req = 1'b0; we = 1'b0;
    chk("held acks", acks, 32'd1);
    @(negedge clk);
    @(negedge clk);
    tbl.push_back(mk("rd ctrl held", 0, 3, 0, 1, 32'h5,  0));
    tbl.push_back(mk("rd alarm held", 0, 1, 0, 1, 32'h50, 0));
    run_tbl();

    // W1C of pending in the same cycle as a fresh hit
    step_cnt(32'h4F);
    step_cnt(32'h50);
    @(negedge clk);
    chk("w1c pre irq", {31'd0, irq}, 32'd1);
    cnt = 32'h4F;
    bus_op(1'b1, 2'd3, 32'h105, 1'b1, 32'h50, rd);
    tbl.push_back(mk("rd ctrl w1c+hit", 0, 3, 0,       1, 32'h305, 1));
    tbl.push_back(mk("wr period7",      1, 2, 32'd7,   0, 0,       1));
    run_tbl();

    // Reset while the response is in flight
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 2'd1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst resp ack",   {31'd0, ack}, 32'd0);
    chk("rst resp rdata", rdata, 32'd0);
    chk("rst resp irq",   {31'd0, irq}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst hold ack", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    tbl.push_back(mk("rd alarm post", 0, 1, 0, 1, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk("rd period post", 0, 2, 0, 1, 32'h0,        0));
    tbl.push_back(mk("rd ctrl post",  0, 3, 0, 1, 32'h0,         0));
    run_tbl();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
